// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package ram_arb_pkg;

  // Number of masters: 0 = data port, 1 = instruction port.
  localparam int NM = 2;

  // Storage provisioned in the response FIFO (largest legal MAX_OUTST).
  localparam int MAX_DEPTH = 4;

  // Identifies which master owns an outstanding slave transaction.
  typedef logic [0:0] owner_id_t;

  // Arbitration state: FREE = round-robin, LOCKED = one master holds the bus.
  typedef enum logic [0:0] {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // The other master of the pair.
  function automatic owner_id_t other_id(input owner_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/ram_arb_rsp_fifo.sv
// Owner-ID FIFO: remembers which master issued each outstanding slave
// transaction so that responses can be routed back in order.
module ram_arb_rsp_fifo
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  owner_id_t  push_id_i,
  input  logic       pop_i,
  output owner_id_t  head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [2:0] count_o
);

  owner_id_t  mem_q [MAX_DEPTH];
  owner_id_t  mem_d [MAX_DEPTH];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;

  // Pointers wrap at DEPTH, not at the provisioned storage size.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Next-state: the caller never pushes while full unless it also pops,
  // and never pops while empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + 3'(push_i) - 3'(pop_i);
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 3'(DEPTH));
  assign empty_o = (count_q == 3'd0);
  assign count_o = count_q;

endmodule

// File: rtl/ram_arbiter.sv
// Two-master RAM arbiter with round-robin selection, lock (atomic) support
// and in-order response routing.
//
// Handshake: a slave transaction is accepted in any cycle where
// s_req_o && s_gnt_i; the winning master sees m_gnt_o[i] in that same cycle.
// Every accepted transaction (read or write) is answered by exactly one
// s_rvalid_i pulse, in acceptance order, which is forwarded as
// m_rvalid_o[owner] with s_rdata_i broadcast on every m_rdata_o lane.
module ram_arbiter #(
  parameter int MAX_OUTST = 2,
  parameter int NM        = ram_arb_pkg::NM
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NM-1:0]             m_req_i,
  input  logic [NM-1:0]             m_lock_i,
  input  logic [NM-1:0]             m_we_i,
  input  logic [NM-1:0][3:0]        m_be_i,
  input  logic [NM-1:0][31:0]       m_addr_i,
  input  logic [NM-1:0][31:0]       m_wdata_i,
  output logic [NM-1:0]             m_gnt_o,
  output logic [NM-1:0]             m_rvalid_o,
  output logic [NM-1:0][31:0]       m_rdata_o,
  output logic                      s_req_o,
  output logic                      s_we_o,
  output logic [3:0]                s_be_o,
  output logic [31:0]               s_addr_o,
  output logic [31:0]               s_wdata_o,
  input  logic                      s_gnt_i,
  input  logic                      s_rvalid_i,
  input  logic [31:0]               s_rdata_i,
  output logic                      err_o,
  output ram_arb_pkg::arb_state_e   dbg_state_o,
  output logic [2:0]                dbg_occupancy_o
);

  import ram_arb_pkg::*;

  arb_state_e state_q, state_d;
  owner_id_t  owner_q, owner_d;     // lock owner while LOCKED
  owner_id_t  last_q, last_d;       // master accepted most recently
  logic       rst_seen_q, rst_seen_d; // high in the first cycle after reset
  logic       err_q, err_d;

  logic       cand_valid;
  owner_id_t  cand_id;
  logic       sel_valid;
  logic       accept;
  logic       fifo_pop;
  owner_id_t  head_id;
  logic       fifo_full;
  logic       fifo_empty;

  // Pick a candidate master: the owner when locked, otherwise round-robin.
  always_comb begin
    cand_valid = 1'b0;
    cand_id    = '0;
    if (state_q == ST_LOCKED) begin
      cand_valid = m_req_i[owner_q];
      cand_id    = owner_q;
    end else if (m_req_i[0] && m_req_i[1]) begin
      cand_valid = 1'b1;
      cand_id    = other_id(last_q);
    end else if (m_req_i[0]) begin
      cand_valid = 1'b1;
      cand_id    = 1'b0;
    end else if (m_req_i[1]) begin
      cand_valid = 1'b1;
      cand_id    = 1'b1;
    end
  end

  // A full response queue blocks issue even if a response drains it this cycle.
  assign sel_valid = cand_valid && !fifo_full && !rst_i;
  assign accept    = sel_valid && s_gnt_i;
  assign fifo_pop  = s_rvalid_i && !fifo_empty && !rst_i;

  // Command mux and grant/response routing; everything idles at zero.
  always_comb begin
    s_req_o    = sel_valid;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (sel_valid) begin
      s_we_o           = m_we_i[cand_id];
      s_be_o           = m_be_i[cand_id];
      s_addr_o         = m_addr_i[cand_id];
      s_wdata_o        = m_wdata_i[cand_id];
      m_gnt_o[cand_id] = s_gnt_i;
    end
    if (fifo_pop) begin
      m_rvalid_o[head_id] = 1'b1;
    end
  end

  assign m_rdata_o = {NM{s_rdata_i}};

  // FSM next-state, round-robin pointer and sticky error.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    rst_seen_d = 1'b0;
    // A response right after reset belongs to a pre-reset transaction: drop it.
    err_d      = err_q | (s_rvalid_i && fifo_empty && !rst_seen_q);
    if (accept) begin
      last_d = cand_id;
    end
    case (state_q)
      ST_FREE: begin
        if (accept && m_lock_i[cand_id]) begin
          state_d = ST_LOCKED;
          owner_d = cand_id;
        end
      end
      ST_LOCKED: begin
        if (!m_lock_i[owner_q]) begin
          state_d = ST_FREE;
        end
      end
      default: state_d = ST_FREE;
    endcase
  end

  // State registers; reset leaves master 0 as winner of the first conflict.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_FREE;
      owner_q    <= '0;
      last_q     <= 1'b1;
      rst_seen_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      rst_seen_q <= rst_seen_d;
      err_q      <= err_d;
    end
  end

  ram_arb_rsp_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_rsp_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (accept),
    .push_id_i (cand_id),
    .pop_i     (fifo_pop),
    .head_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (dbg_occupancy_o)
  );

  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios, a queue-based reference model
// checked every cycle, and literal expectations per scenario.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int MO = 2;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [1:0]        m_req_i = '0;
  logic [1:0]        m_lock_i = '0;
  logic [1:0]        m_we_i = '0;
  logic [1:0][3:0]   m_be_i = '0;
  logic [1:0][31:0]  m_addr_i = '0;
  logic [1:0][31:0]  m_wdata_i = '0;
  logic [1:0]        m_gnt_o;
  logic [1:0]        m_rvalid_o;
  logic [1:0][31:0]  m_rdata_o;
  logic              s_req_o, s_we_o;
  logic [3:0]        s_be_o;
  logic [31:0]       s_addr_o, s_wdata_o;
  logic              s_gnt_i = 1'b0;
  logic              s_rvalid_i = 1'b0;
  logic [31:0]       s_rdata_i = '0;
  logic              err_o;
  arb_state_e        dbg_state;
  logic [2:0]        dbg_occ;

  always #5 clk = ~clk;

  ram_arbiter #(.MAX_OUTST(MO)) dut (
    .clk_i (clk), .rst_i (rst_i),
    .m_req_i (m_req_i), .m_lock_i (m_lock_i), .m_we_i (m_we_i),
    .m_be_i (m_be_i), .m_addr_i (m_addr_i), .m_wdata_i (m_wdata_i),
    .m_gnt_o (m_gnt_o), .m_rvalid_o (m_rvalid_o), .m_rdata_o (m_rdata_o),
    .s_req_o (s_req_o), .s_we_o (s_we_o), .s_be_o (s_be_o),
    .s_addr_o (s_addr_o), .s_wdata_o (s_wdata_o),
    .s_gnt_i (s_gnt_i), .s_rvalid_i (s_rvalid_i), .s_rdata_i (s_rdata_i),
    .err_o (err_o), .dbg_state_o (dbg_state), .dbg_occupancy_o (dbg_occ)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Reference model state.
  int          lock_owner = -1;
  int          last_win = 1;
  int          outq[$];
  bit          m_err = 1'b0;
  bit          post_rst = 1'b0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] slave_q[$];
  int          acc_id_q[$];
  int          acc_cyc_q[$];
  int          rv_cnt [2] = '{0, 0};
  int          cyc = 0;
  bit          auto_rsp = 1'b0;

  // Compare process: every cycle, derive expected outputs from the rules.
  always @(negedge clk) begin : compare
    int          cand;
    logic [1:0]  e_gnt, e_rv;
    logic [31:0] e_addr, e_wd, d;
    logic        e_we;
    logic [3:0]  e_be;
    cand = -1;
    if (!rst_i) begin
      if (lock_owner >= 0) begin
        if (m_req_i[lock_owner]) cand = lock_owner;
      end else if (m_req_i == 2'b11) cand = 1 - last_win;
      else if (m_req_i[0]) cand = 0;
      else if (m_req_i[1]) cand = 1;
      if (outq.size() >= MO) cand = -1;
    end
    e_gnt = '0; e_addr = '0; e_wd = '0; e_we = 1'b0; e_be = '0; e_rv = '0;
    if (cand >= 0) begin
      e_addr = m_addr_i[cand];
      e_wd   = m_wdata_i[cand];
      e_we   = m_we_i[cand];
      e_be   = m_be_i[cand];
      if (s_gnt_i) e_gnt[cand] = 1'b1;
    end
    if (!rst_i && s_rvalid_i && outq.size() > 0) e_rv[outq[0]] = 1'b1;
    check("s_req", 64'(s_req_o), 64'(cand >= 0));
    check("m_gnt", 64'(m_gnt_o), 64'(e_gnt));
    check("s_addr", 64'(s_addr_o), 64'(e_addr));
    check("s_wdata", 64'(s_wdata_o), 64'(e_wd));
    check("s_we_be", 64'({s_we_o, s_be_o}), 64'({e_we, e_be}));
    check("m_rvalid", 64'(m_rvalid_o), 64'(e_rv));
    check("err", 64'(err_o), 64'(m_err));
    if (e_rv[0]) begin
      d = exp_q0.pop_front();
      check("m0_rdata", 64'(m_rdata_o[0]), 64'(d));
      rv_cnt[0]++;
    end
    if (e_rv[1]) begin
      d = exp_q1.pop_front();
      check("m1_rdata", 64'(m_rdata_o[1]), 64'(d));
      rv_cnt[1]++;
    end
    // Advance the model to the state after the coming rising edge.
    if (rst_i) begin
      lock_owner = -1; last_win = 1; outq.delete();
      exp_q0.delete(); exp_q1.delete(); m_err = 1'b0; post_rst = 1'b1;
    end else begin
      if (s_rvalid_i) begin
        if (outq.size() > 0) void'(outq.pop_front());
        else if (!post_rst) m_err = 1'b1;
      end
      if (lock_owner >= 0 && !m_lock_i[lock_owner]) lock_owner = -1;
      if (cand >= 0 && s_gnt_i) begin
        outq.push_back(cand);
        last_win = cand;
        if (cand == 0) exp_q0.push_back(m_we_i[0] ? 32'h0 : rd_of(m_addr_i[0]));
        else exp_q1.push_back(m_we_i[1] ? 32'h0 : rd_of(m_addr_i[1]));
        acc_id_q.push_back(cand);
        acc_cyc_q.push_back(cyc);
        if (lock_owner < 0 && m_lock_i[cand]) lock_owner = cand;
      end
      post_rst = 1'b0;
    end
    // Slave memory: remember what each accepted transaction will return.
    if (s_req_o && s_gnt_i) slave_q.push_back(s_we_o ? 32'h0 : rd_of(s_addr_o));
    cyc++;
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_rsp && slave_q.size() > 0) begin
      s_rvalid_i = 1'b1;
      s_rdata_i  = slave_q.pop_front();
    end else begin
      s_rvalid_i = 1'b0;
      s_rdata_i  = '0;
    end
  endtask

  task automatic respond();
    s_rvalid_i = 1'b1;
    if (slave_q.size() > 0) s_rdata_i = slave_q.pop_front();
    else s_rdata_i = 32'h0BAD_0BAD;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_m(input int i, input bit req, input bit lock, input bit we,
                         input logic [31:0] addr);
    m_req_i[i]   = req;
    m_lock_i[i]  = lock;
    m_we_i[i]    = we;
    m_addr_i[i]  = addr;
    m_wdata_i[i] = addr ^ 32'h5555_0000;
    m_be_i[i]    = we ? 4'b0011 : 4'b1111;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, b0, r0, r1;
    // Reset with both masters requesting: nothing may leak out.
    s_gnt_i = 1'b1;
    drive_m(0, 1, 0, 0, 32'h10);
    drive_m(1, 1, 0, 0, 32'h20);
    step(); step();
    settle();
    check("rst_state", 64'(dbg_state), 64'(ST_FREE));
    check("rst_occ", 64'(dbg_occ), 64'd0);
    check("rst_req", 64'(s_req_o), 64'd0);
    check("rst_gnt", 64'(m_gnt_o), 64'd0);
    step();
    rst_i = 1'b0;
    drive_m(0, 0, 0, 0, 0);
    drive_m(1, 0, 0, 0, 0);
    step();

    // Both masters read every cycle: grants alternate starting with master 0.
    auto_rsp = 1'b1;
    base = acc_id_q.size(); r0 = rv_cnt[0]; r1 = rv_cnt[1];
    for (int k = 0; k < 4; k++) begin
      drive_m(0, 1, 0, 0, 32'h1000 + 32'(k * 4));
      drive_m(1, 1, 0, 0, 32'h2000 + 32'(k * 4));
      step();
    end
    drive_m(0, 0, 0, 0, 0);
    drive_m(1, 0, 0, 0, 0);
    step(); step(); step();
    check("rr_count", 64'(acc_id_q.size() - base), 64'd4);
    for (int k = 0; k < 4; k++) check("rr_order", 64'(acc_id_q[base + k]), 64'(k % 2));
    check("rr_rsp0", 64'(rv_cnt[0] - r0), 64'd2);
    check("rr_rsp1", 64'(rv_cnt[1] - r1), 64'd2);

    // Master 0 write stalled by the slave, then granted.
    s_gnt_i = 1'b0;
    drive_m(0, 1, 0, 1, 32'h300);
    settle();
    check("stall_req", 64'(s_req_o), 64'd1);
    check("stall_gnt", 64'(m_gnt_o), 64'd0);
    step();
    s_gnt_i = 1'b1;
    step();
    // Master 1 locks for three cycles while master 0 keeps requesting.
    base = acc_id_q.size(); b0 = cyc;
    for (int k = 0; k < 3; k++) begin
      drive_m(0, 1, 0, 1, 32'h304);
      drive_m(1, 1, 1, 0, 32'h100);
      step();
    end
    drive_m(1, 0, 0, 0, 0);
    step();
    step();
    drive_m(0, 0, 0, 0, 0);
    step(); step();
    check("lock_count", 64'(acc_id_q.size() - base), 64'd4);
    for (int k = 0; k < 3; k++) begin
      check("lock_owner_id", 64'(acc_id_q[base + k]), 64'd1);
      check("lock_owner_cyc", 64'(acc_cyc_q[base + k]), 64'(b0 + k));
    end
    check("lock_m0_id", 64'(acc_id_q[base + 3]), 64'd0);
    check("lock_m0_cyc", 64'(acc_cyc_q[base + 3]), 64'(b0 + 4));

    // Slave withholds responses: two acceptances, then issue stops.
    auto_rsp = 1'b0;
    step();
    base = acc_id_q.size();
    drive_m(0, 1, 0, 0, 32'h400);
    step(); step(); step();
    respond();
    settle();
    check("full_req", 64'(s_req_o), 64'd0);
    check("full_count", 64'(acc_id_q.size() - base), 64'd2);
    step();
    settle();
    check("resume_gnt", 64'(m_gnt_o), 64'd1);
    check("resume_count", 64'(acc_id_q.size() - base), 64'd3);
    step();
    drive_m(0, 0, 0, 0, 0);
    respond();
    step();
    respond();
    step();
    step();

    // Unsolicited response: not forwarded, error latches until reset.
    respond();
    settle();
    check("unsol_rvalid", 64'(m_rvalid_o), 64'd0);
    step();
    settle();
    check("err_set", 64'(err_o), 64'd1);
    step(); step();
    settle();
    check("err_sticky", 64'(err_o), 64'd1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    settle();
    check("err_cleared", 64'(err_o), 64'd0);

    // Reset with one transaction outstanding; its late response is dropped.
    step();
    drive_m(0, 1, 0, 0, 32'h500);
    step();
    rst_i = 1'b1;
    drive_m(1, 1, 0, 0, 32'h600);
    s_rvalid_i = 1'b0;
    step();
    rst_i = 1'b0;
    drive_m(0, 0, 0, 0, 0);
    drive_m(1, 0, 0, 0, 0);
    respond();
    settle();
    check("post_rst_state", 64'(dbg_state), 64'(ST_FREE));
    check("post_rst_occ", 64'(dbg_occ), 64'd0);
    check("stale_rvalid", 64'(m_rvalid_o), 64'd0);
    step();
    settle();
    check("stale_err", 64'(err_o), 64'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 2, the maximum number of accepted but unanswered slave transactions (legal range 1..4).
REQ-002 SHALL have parameter NM, fixed 2, the number of masters (index 0 = data port, index 1 = instruction port).
REQ-003 SHALL have the following ports, one per line: name, direction, width, meaning.
  clk_i  in  1  single clock; all logic on rising edge.
  rst_i  in  1  synchronous, active-high reset.
  m_req_i  in  NM  per-master request.
  m_lock_i  in  NM  per-master lock hold (atomic sequence).
  m_we_i  in  NM  per-master write enable.
  m_be_i  in  NMx4  per-master byte enables.
  m_addr_i  in  NMx32  per-master address.
  m_wdata_i  in  NMx32  per-master write data.
  m_gnt_o  out  NM  per-master grant.
  m_rvalid_o  out  NM  per-master response valid.
  m_rdata_o  out  NMx32  per-master read data (broadcast s_rdata_i).
  s_req_o, s_we_o  out  1  slave request and write enable.
  s_be_o  out  4  slave byte enables.
  s_addr_o, s_wdata_o  out  32  slave address and write data.
  s_gnt_i, s_rvalid_i  in  1  slave grant and response valid.
  s_rdata_i  in  32  slave read data.
  err_o  out  1  sticky protocol error.

Function
REQ-004 SHALL decide arbitration combinationally in the same cycle: s_req_o and the muxed command follow the selected master; m_gnt_o[i] = selected(i) AND s_gnt_i.
REQ-005 SHALL accept a transaction when s_req_o AND s_gnt_i; every accepted transaction, read or write, receives exactly one s_rvalid_i.
REQ-006 SHALL, in state FREE with both masters requesting, select the master not granted most recently (round-robin pointer); the pointer updates only on acceptance.
REQ-007 SHALL implement FSM states FREE and LOCKED; FREE->LOCKED when an accepted master has m_lock_i high; LOCKED->FREE in the cycle the owner's m_lock_i is sampled low.
REQ-008 SHALL, in LOCKED, select only the lock owner; other masters see m_gnt_o=0 regardless of request.
REQ-009 SHALL keep an owner-ID queue of depth MAX_OUTST: push the selected ID on acceptance, pop on s_rvalid_i, and route m_rvalid_o[head]=1 for that cycle.
REQ-010 SHALL, on simultaneous push and pop, keep occupancy unchanged and preserve order.
REQ-011 SHALL suppress s_req_o when registered occupancy equals MAX_OUTST, even if a pop occurs in the same cycle.
REQ-012 SHALL, on s_rvalid_i with an empty queue, assert no m_rvalid_o and set err_o, which stays set until reset.
REQ-013 SHALL drive all s_* command outputs to zero when no master is selected.

Reset
REQ-014 SHALL, while rst_i is high at a clock edge: set the FSM to FREE, the pointer so master 0 wins the first conflict, queue occupancy to 0, and err_o to 0.
REQ-015 SHALL hold s_req_o=0, m_gnt_o=0, and m_rvalid_o=0 during reset; a response arriving for a transaction issued before reset is dropped without setting err_o in the first cycle after reset.

Structure
REQ-016 SHALL place the owner-ID typedef, the FSM state enum, and the NM constant in package ram_arb_pkg.
REQ-017 SHALL implement the owner-ID queue as sub-module ram_arb_rsp_fifo, which provides push, pop, head, full, and empty.

Verification
REQ-018 Both masters request reads every cycle with s_gnt_i=1 and rvalid one cycle later -> grants alternate 0,1,0,1; each master receives its own rdata in order.
REQ-019 Master 1 asserts req+lock at 0x100 for 3 cycles while master 0 requests -> master 1 is granted 3 times and master 0 gets no grant until the cycle after lock drops.
REQ-020 MAX_OUTST=2, slave withholds s_rvalid_i -> exactly 2 acceptances occur, then s_req_o=0; one s_rvalid_i arrives -> the next grant resumes one cycle later.
REQ-021 Unsolicited s_rvalid_i with the queue empty -> no m_rvalid_o is asserted, err_o=1, and err_o stays 1 until rst_i.
REQ-022 rst_i is asserted for 1 cycle with 1 transaction outstanding -> occupancy=0 and the FSM is FREE; the stale rvalid in the next cycle is dropped and err_o stays 0.
